// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch front end. Issues in-order requests to a
//                valid/ready instruction memory, keeps a 2-entry in-order
//                buffer of {inst, pc}, presents the head to the IF/ID
//                register and flushes on a redirect from EX.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_ID_Stall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instOut,
    output logic [31:0] PC,
    output logic        inst_valid
);

    localparam logic [1:0] c_CREDITS = 2'd2;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_resp_pc;
    logic [31:0] r_buf_inst [2];
    logic [31:0] r_buf_pc   [2];
    logic [1:0]  r_buf_count;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop_cnt;

    logic        w_pop;
    logic        w_rsp;
    logic        w_push;
    logic        w_drop;
    logic        w_accept;
    logic [2:0]  w_occupancy;
    logic [1:0]  w_count_after_pop;
    logic        w_wr_slot;

    // Head of the buffer drives the IF/ID inputs; reset masks it immediately.
    assign inst_valid = !rst && (r_buf_count != 2'd0);
    assign instOut    = inst_valid ? r_buf_inst[0] : NOP_INST;
    assign PC         = inst_valid ? r_buf_pc[0]   : 32'd0;
    assign w_pop      = inst_valid && !IF_ID_Stall;

    // Credit check: buffered plus in-flight entries must stay within two.
    // The head leaving this cycle frees its slot before any new response can
    // land (latency >= 1), which is what lets a latency-1 memory stream one
    // instruction per cycle.
    assign w_occupancy = {1'b0, r_buf_count} + {1'b0, r_outstanding} - {2'b00, w_pop};
    assign imem_req    = !rst && !Redirect && (w_occupancy < {1'b0, c_CREDITS});
    assign imem_addr   = r_fetch_pc;
    assign w_accept    = imem_req && imem_ready;

    // A response with nothing outstanding is ignored rather than underflowing.
    assign w_rsp  = imem_rvalid && (r_outstanding != 2'd0);
    assign w_drop = w_rsp && (r_drop_cnt != 2'd0);
    assign w_push = w_rsp && (r_drop_cnt == 2'd0) && !Redirect && !rst;

    // Slot for an arriving response: directly behind whatever survives the pop.
    assign w_count_after_pop = r_buf_count - {1'b0, w_pop};
    assign w_wr_slot         = w_count_after_pop[0];

    // Control state: PCs, occupancy, in-flight and to-be-discarded counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_buf_count   <= 2'd0;
            r_outstanding <= 2'd0;
            r_drop_cnt    <= 2'd0;
        end else if (Redirect) begin
            // Everything still in flight belongs to the wrong path; count it
            // so the responses can be swallowed as they return.
            r_fetch_pc    <= Redirect_PC;
            r_resp_pc     <= Redirect_PC;
            r_buf_count   <= 2'd0;
            r_outstanding <= r_outstanding - {1'b0, w_rsp};
            r_drop_cnt    <= r_outstanding - {1'b0, w_rsp};
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 2'd1;
            end
            r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_rsp};
            r_buf_count   <= w_count_after_pop + {1'b0, w_push};
        end
    end

    // Buffer payload: shift forward on pop, then write the arriving response.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_buf_inst[0] <= r_buf_inst[1];
            r_buf_pc[0]   <= r_buf_pc[1];
        end
        if (w_push) begin
            if (w_wr_slot == 1'b0) begin
                r_buf_inst[0] <= imem_rdata;
                r_buf_pc[0]   <= r_resp_pc;
            end else begin
                r_buf_inst[1] <= imem_rdata;
                r_buf_pc[1]   <= r_resp_pc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a behavioural
//                in-order instruction memory of configurable latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        IF_ID_Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_PC = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instOut;
    logic [31:0] PC;
    logic        inst_valid;

    int errors = 0;
    int checks = 0;

    fetch_unit #(
        .RESET_PC (c_RESET_PC),
        .NOP_INST (c_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IF_ID_Stall (IF_ID_Stall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instOut     (instOut),
        .PC          (PC),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural memory: in order, fixed latency ----------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] xr  = 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'd0;
            cyc         <= 0;
        end else begin
            if (imem_rvalid && mq.size() > 0) begin
                void'(mq.pop_front());
            end
            if (imem_req && imem_ready) begin
                mq.push_back('{imem_addr, cyc + lat});
            end
            if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mq[0].addr ^ xr;
            end else begin
                imem_rvalid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    // ---------------- helpers ----------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_max(input string name, input int act, input int mx);
        checks++;
        if (act > mx) begin
            errors++;
            $display("FAIL %s: got %0d expected <= %0d", name, act, mx);
        end
    endtask

    task automatic tick(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        @(negedge clk);
        IF_ID_Stall = s;
        Redirect    = r;
        Redirect_PC = rp;
        imem_ready  = rdy;
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
        chk({tag, "_inst"},  instOut, c_NOP);
        chk({tag, "_pc"},    PC, 32'd0);
        chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    endtask

    // One reset cycle (outputs checked while rst is high), then release;
    // returns inside cycle 0 after release.
    task automatic do_reset(input int l, input logic [31:0] x, input logic rdy0);
        @(negedge clk);
        rst = 1'b1; IF_ID_Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
        imem_ready = 1'b1; lat = l; xr = x;
        #1;
        chk_idle("in_reset");
        @(negedge clk);
        rst = 1'b0; imem_ready = rdy0;
        #1;
    endtask

    // ---------------- table-driven stream + stall ---------------------------
    typedef struct {
        logic        stall;
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [31:0] nxt;
        int          consumed;
        int          waited;
        logic        seen;

        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] nxt;
        int          consumed;
        int          waited;
        logic        seen;

        // Latency 1, data == address, head stalled for 4 cycles at PC 8.
        vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0C};
        vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h10};
        vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h10};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h10};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h10};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h14};
        vt[10] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h18};
        vt[11] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h1C};

        do_reset(1, 32'd0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            IF_ID_Stall = vt[i].stall;
            imem_ready  = vt[i].ready;
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].exp_valid});
            chk($sformatf("v%0d_pc", i),    PC, vt[i].exp_valid ? vt[i].exp_pc : 32'd0);
            chk($sformatf("v%0d_inst", i),  instOut, vt[i].exp_valid ? vt[i].exp_pc : c_NOP);
            chk($sformatf("v%0d_req", i),   {31'd0, imem_req}, {31'd0, vt[i].exp_req});
            chk($sformatf("v%0d_addr", i),  imem_addr, vt[i].exp_addr);
        end

        // ---- two requests in flight, back-to-back redirects ----------------
        do_reset(3, 32'hA5A5_0000, 1'b0);
        tick(1'b0, 1'b1, 32'h10, 1'b1);        // c1: redirect to 0x10
        chk("rd1_req_blocked", {31'd0, imem_req}, 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c2: request 0x10
        chk("rd1_addr10", imem_addr, 32'h10);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c3: request 0x14
        chk("rd1_addr14", imem_addr, 32'h14);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c4: credit exhausted
        chk("rd1_credit_req", {31'd0, imem_req}, 32'd0);
        Redirect = 1'b1; Redirect_PC = 32'h300;
        tick(1'b0, 1'b1, 32'h100, 1'b1);       // c5: 0x10 returns, latest target wins
        chk("rd1_flush_valid", {31'd0, inst_valid}, 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c6: 0x14 returns and is dropped
        chk("rd1_new_req", {31'd0, imem_req}, 32'd1);
        chk("rd1_new_addr", imem_addr, 32'h100);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (inst_valid) begin
                seen = 1'b1;
                chk("rd1_first_pc", PC, 32'h100);
                chk("rd1_first_inst", instOut, 32'h100 ^ 32'hA5A5_0000);
            end
        end
        chk("rd1_arrived", {31'd0, seen}, 32'd1);

        // ---- redirect coincident with a response, under stall -------------
        do_reset(1, 32'h3C3C_0000, 1'b0);
        tick(1'b0, 1'b1, 32'h20, 1'b1);        // c1
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c2: request 0x20
        chk("rd2_addr20", imem_addr, 32'h20);
        tick(1'b1, 1'b1, 32'h200, 1'b1);       // c3: response 0x20 + redirect
        chk("rd2_req_blocked", {31'd0, imem_req}, 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c4
        chk("rd2_valid_after", {31'd0, inst_valid}, 32'd0);
        chk("rd2_req", {31'd0, imem_req}, 32'd1);
        chk("rd2_addr", imem_addr, 32'h200);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c5: response 0x200
        chk("rd2_valid_c5", {31'd0, inst_valid}, 32'd0);
        tick(1'b0, 1'b0, 32'h0, 1'b1);         // c6
        chk("rd2_valid_c6", {31'd0, inst_valid}, 32'd1);
        chk("rd2_pc", PC, 32'h200);
        chk("rd2_inst", instOut, 32'h200 ^ 32'h3C3C_0000);

        // ---- ready toggling, latency 3, sporadic stall ---------------------
        do_reset(3, 32'h5A5A_0000, 1'b1);
        chk("tog_c0_addr", imem_addr, c_RESET_PC);
        nxt = c_RESET_PC;
        consumed = 0;
        for (int i = 1; i < 90; i++) begin
            tick((i % 5) == 3, 1'b0, 32'h0, i[0]);
            if (inst_valid && !IF_ID_Stall) begin
                chk($sformatf("tog_pc%0d", consumed), PC, nxt);
                chk($sformatf("tog_inst%0d", consumed), instOut, nxt ^ 32'h5A5A_0000);
                nxt = nxt + 32'd4;
                consumed++;
            end
            chk_max("tog_inflight", mq.size(), 2);
            chk_max("tog_occupancy", int'(dut.r_buf_count) + int'(dut.r_outstanding), 2);
        end
        checks++;
        if (consumed < 15) begin
            errors++;
            $display("FAIL tog_throughput: got %0d expected >= 15", consumed);
        end

        // ---- reset with a full buffer ---------------------------------------
        do_reset(1, 32'h0F0F_0000, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_full_valid", {31'd0, inst_valid}, 32'd1);
        chk("rst_full_pc", PC, 32'h0);
        chk("rst_full_inst", instOut, 32'h0F0F_0000);
        chk("rst_full_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("rst_asserted");
        @(negedge clk);
        rst = 1'b0; IF_ID_Stall = 1'b0;
        #1;
        chk("rst_rel_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_rel_inst", instOut, c_NOP);
        chk("rst_rel_req", {31'd0, imem_req}, 32'd1);
        chk("rst_rel_addr", imem_addr, c_RESET_PC);
        waited = 0;
        while (!inst_valid && waited < 10) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            waited++;
        end
        chk("rst_rel_latency", waited, 2);
        chk("rst_rel_pc", PC, c_RESET_PC);
        chk("rst_rel_data", instOut, c_RESET_PC ^ 32'h0F0F_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
